// File: rtl/clk_div_pkg.sv
// Shared definitions for the runtime-programmable clock divider.
package clk_div_pkg;

    // Controller FSM state encoding
    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PEND  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    // Smallest divisor the controller will accept
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period counter and 50% duty clock generation for even and odd divisors.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             run_nxt,
    input  logic [DIV_W-1:0] cur_div,
    output logic             bnd,
    output logic             tick,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic             p;
    logic             n;

    // ceil(d/2) in DIV_W bits; cannot overflow because d <= 2**DIV_W-1
    function automatic logic [DIV_W-1:0] ceil_half(input logic [DIV_W-1:0] d);
        return (d >> 1) + {{(DIV_W-1){1'b0}}, d[0]};
    endfunction

    assign bnd = run && (cnt == cur_div - DIV_W'(1));

    // Next counter value: count while running, wrap at the boundary, hold 0 when stopped
    always_comb begin
        cnt_nxt = '0;
        if (run && !bnd) begin
            cnt_nxt = cnt + DIV_W'(1);
        end
    end

    // Counter, high-phase flop and tick are computed from the next count so they align with cnt
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt  <= '0;
            p    <= 1'b0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            p    <= run_nxt && (cnt_nxt < ceil_half(cur_div));
            tick <= run_nxt && (cnt_nxt == '0);
        end
    end

    // Half-cycle delayed copy of p; ANDing with it trims odd high phases to N/2
    always_ff @(negedge clk) begin
        if (!reset) begin
            n <= 1'b0;
        end else begin
            n <= p;
        end
    end

    // Flop-only output: even divisors use p directly, odd ones the overlap of p and n
    assign clk_out = cur_div[0] ? (p & n) : p;

endmodule

// File: rtl/clk_div_sequencer.sv
// Divider controller: owns the divisor, handles req/ack changes at period boundaries.
module clk_div_sequencer
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 5
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div,
    output logic             tick,
    output logic             clk_out
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] pending;
    logic             bnd;
    logic             req_take;
    logic             req_bad;
    logic             req_ok;

    // State register
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state <= OFF;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a valid request in RUN wins over a simultaneous stop
    always_comb begin
        state_nxt = state;
        unique case (state)
            OFF:     if (enable) state_nxt = RUN;
            RUN:     if (req_ok) state_nxt = PEND;
                     else if (!enable) state_nxt = DRAIN;
            PEND:    if (bnd) state_nxt = enable ? RUN : OFF;
            DRAIN:   if (enable) state_nxt = RUN;
                     else if (bnd) state_nxt = OFF;
            default: state_nxt = OFF;
        endcase
    end

    // Outputs and request qualification decoded from the current state
    always_comb begin
        busy     = (state == PEND);
        req_take = div_req && !busy && ((state == OFF) || (state == RUN));
        req_bad  = req_take && (div_val < DIV_W'(MIN_DIV));
        req_ok   = req_take && !req_bad;
    end

    // Divisor, pending value and handshake pulses
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cur_div <= DIV_W'(DEF_DIV);
            pending <= '0;
            div_ack <= 1'b0;
            div_err <= 1'b0;
        end else begin
            div_ack <= ((state == OFF) && req_ok) || ((state == PEND) && bnd);
            div_err <= req_bad;
            if ((state == OFF) && req_ok) begin
                cur_div <= div_val;
            end else if ((state == PEND) && bnd) begin
                cur_div <= pending;
            end
            if ((state == RUN) && req_ok) begin
                pending <= div_val;
            end
        end
    end

    clk_div_core #(
        .DIV_W(DIV_W)
    ) u_core (
        .clk     (clk_in),
        .reset   (reset),
        .run     (state != OFF),
        .run_nxt (state_nxt != OFF),
        .cur_div (cur_div),
        .bnd     (bnd),
        .tick    (tick),
        .clk_out (clk_out)
    );

endmodule
